muldiv_unit: RTL and testbench
==============================

# muldiv_unit

Iterative multiply/divide unit implementing the eight RV32M operations, selected by `funct3` exactly as the instruction encodes them. It sits beside the main ALU in the execute stage. The main decoder raises `start` for R-type instructions with funct7 = 0000001. It is parametrised in operand width and uses a fixed-latency start/busy/done handshake, so the pipeline stall logic has no data-dependent cases.

## Interface
- `XLEN`, default 32: operand and result width; must be even and ≥ 4.
- `clk`  in  1  clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `start`  in  1  request; sampled only in IDLE.
- `flush`  in  1  synchronous abort from the hazard unit.
- `funct3`  in  3  operation: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- `a`  in  XLEN  rs1 operand; sampled with an accepted `start`.
- `b`  in  XLEN  rs2 operand; sampled with an accepted `start`.
- `busy`  out  1  high while the operation is in progress.
- `done`  out  1  one-cycle pulse; `result` is valid while it is high.
- `result`  out  XLEN  registered result; held until the next accepted `start`.

## Operation
- Four states: IDLE, CALC, FIX, DONE.
- IDLE → CALC on `start` && !`flush`.
  - On this edge the unit latches `funct3`.
  - It latches |a| and |b| as unsigned magnitudes. The signed interpretation applies only where the op calls for it: a for MUL/MULH/MULHSU/DIV/REM; b for MUL/MULH/DIV/REM.
  - It records the result sign and clears the iteration counter.
- CALC lasts exactly XLEN cycles. Each cycle performs one step and increments the counter. On count = XLEN−1 the unit moves to FIX.
  - Multiply: radix-2 shift-add into a 2·XLEN-bit product register.
  - Divide: radix-2 restoring step on a 2·XLEN-bit remainder/quotient register.
- FIX lasts one cycle. It applies sign correction and writes `result`, then moves to DONE.
  - Two's-complement negation over the full 2·XLEN product.
  - Quotient sign = sign(a) XOR sign(b).
  - Remainder sign = sign(a).
- DONE lasts one cycle with `done`=1, then returns to IDLE. `start` is not accepted in DONE.
- Result selection:
  - MUL returns product[XLEN−1:0]; MULH/MULHSU/MULHU return product[2·XLEN−1:XLEN].
  - DIV/DIVU return the quotient; REM/REMU return the remainder.
- Special cases are resolved in FIX and override the iterative value:
  - Divide by zero: quotient = all ones, for both DIV and DIVU.
  - Divide by zero: remainder = `a` unmodified.
  - Signed overflow, a = −2^(XLEN−1) with b = −1: DIV returns `a`, REM returns 0.
- `busy` = 1 in CALC and FIX, 0 in IDLE and DONE.
- `start` while not in IDLE is ignored, with no side effects.
- The iteration counter is $clog2(XLEN)+1 bits wide.
- `flush` in CALC or FIX:
  - Next state is IDLE and `done` is never raised for that op.
  - `result` keeps its previous value.
- `flush` and `start` in the same IDLE cycle: `flush` wins and nothing is accepted.
- `flush` in DONE has no effect; the pulse still completes.

## Timing
- Reset values: state IDLE, `busy` 0, `done` 0, `result` 0, counter 0, internal registers 0.
- Asserting `reset` mid-operation aborts immediately, with no `done`.
- Latency: `start` accepted at edge k.
  - CALC covers cycles k+1 … k+XLEN.
  - FIX is cycle k+XLEN+1.
  - `done`=1 and `result` are valid in cycle k+XLEN+2.
  - The next `start` can be accepted at the edge ending cycle k+XLEN+3 (IDLE).
- Latency is identical for every op and operand value, including the special cases: XLEN+2 cycles from accept to `done`, which is 34 for XLEN=32.
- Throughput: one operation per XLEN+3 cycles.
- All outputs are registered or decoded from state only; there is no combinational path from inputs to outputs.

## Test plan
- Multiply, XLEN=32:
  - MUL 7 × 0xFFFFFFFD (−3) → 0xFFFFFFEB.
  - `busy`=1 for 33 cycles, `done` pulses exactly once at k+34.
- High-half multiply:
  - MULH 0x80000000 × 0x80000000 → 0x40000000.
  - MULHU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE.
  - MULHSU 0xFFFFFFFF × 2 → 0xFFFFFFFF.
- Divide:
  - DIV −7/2 → 0xFFFFFFFD; REM −7/2 → 0xFFFFFFFF.
  - DIVU 100/7 → 14; REMU 100/7 → 2.
- Divide special cases:
  - DIV 5/0 → 0xFFFFFFFF; REMU 5/0 → 5.
  - DIV 0x80000000 / 0xFFFFFFFF → 0x80000000; REM same operands → 0.
  - Each at the same 34-cycle latency.
- Handshake:
  - `start` pulsed in CALC with different operands → ignored; first op's result is unchanged.
  - `start` held high through DONE → next op accepted only in the following IDLE cycle.
- Abort:
  - `flush` at k+10 → IDLE at k+11, no `done`, `result` keeps the prior value.
  - `reset` asserted mid-CALC → all outputs 0 immediately; a fresh op afterwards completes correctly.
  - XLEN=8 regression: MULHU 0xFF × 0xFF → 0xFE, latency 10.

Source files
------------

// File: rtl/muldiv_unit_if.sv
// muldiv_unit_if
// Request/response bundle between the execute stage and the iterative
// multiply/divide unit.
//   start  : request, only honoured while the unit is idle
//   flush  : synchronous abort from the hazard unit
//   funct3 : RV32M operation select
//   a, b   : rs1 / rs2 operands
//   busy   : operation in progress (CALC and FIX)
//   done   : one-cycle completion pulse, result valid while high
//   result : registered result, held until the next accepted start
interface muldiv_unit_if #(
  parameter int XLEN = 32
);
  logic            start;
  logic            flush;
  logic [2:0]      funct3;
  logic [XLEN-1:0] a;
  logic [XLEN-1:0] b;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] result;

  modport master (
    output start, flush, funct3, a, b,
    input  busy, done, result
  );

  modport slave (
    input  start, flush, funct3, a, b,
    output busy, done, result
  );
endinterface

// File: rtl/muldiv_unit.sv
// muldiv_unit
// Iterative RV32M multiply/divide unit with a fixed latency of XLEN+2
// cycles from accepted start to done, independent of op and operands.
// Ports:
//   clk   : clock, rising edge
//   reset : asynchronous active-high reset
//   bus   : muldiv_unit_if slave (start/flush/funct3/a/b in,
//           busy/done/result out)
//
// state | meaning
// IDLE  | waiting for start
// CALC  | XLEN radix-2 steps (shift-add or restoring divide)
// FIX   | sign correction, special cases, result written
// DONE  | done pulse, result valid
module muldiv_unit #(
  parameter int XLEN = 32
) (
  input  logic          clk,
  input  logic          reset,
  muldiv_unit_if.slave  bus
);

  localparam int CNT_W = $clog2(XLEN) + 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(XLEN - 1);
  localparam logic [XLEN-1:0]  MIN_NEG  = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t            state, state_nx;
  logic [CNT_W-1:0]  cnt;
  logic [2:0]        op;
  logic [XLEN-1:0]   a_raw;
  logic [XLEN-1:0]   mag_b;
  logic              sign_a;
  logic              sign_b;
  logic              div0;
  logic              ovf;
  logic [2*XLEN-1:0] acc;
  logic [XLEN-1:0]   result_q;

  logic              accept;
  logic              signed_a_in;
  logic              signed_b_in;
  logic              neg_a_in;
  logic              neg_b_in;
  logic [XLEN-1:0]   mag_a_in;
  logic [XLEN-1:0]   mag_b_in;

  logic [XLEN:0]     mul_sum;
  logic [2*XLEN-1:0] mul_next;
  logic [XLEN:0]     rem_sh;
  logic              rem_ok;
  logic [XLEN:0]     rem_new;
  logic [2*XLEN-1:0] div_next;

  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   quo_fix;
  logic [XLEN-1:0]   rem_fix;
  logic [XLEN-1:0]   fix_val;

  // ---------------- FSM ----------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (bus.start && !bus.flush) state_nx = CALC;
      CALC: begin
        if (bus.flush)             state_nx = IDLE;
        else if (cnt == LAST_CNT)  state_nx = FIX;
      end
      FIX:  state_nx = bus.flush ? IDLE : DONE;
      DONE: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  assign accept     = (state == IDLE) && bus.start && !bus.flush;
  assign bus.busy   = (state == CALC) || (state == FIX);
  assign bus.done   = (state == DONE);
  assign bus.result = result_q;

  // ---------------- operand decode ----------------
  // a is unsigned only for MULHU/DIVU/REMU; b is signed only for
  // MUL/MULH/DIV/REM.
  always_comb begin
    signed_a_in = !((bus.funct3 == 3'b011) || (bus.funct3[2] && bus.funct3[0]));
    signed_b_in = (!bus.funct3[2] && !bus.funct3[1]) || (bus.funct3[2] && !bus.funct3[0]);
    neg_a_in    = signed_a_in && bus.a[XLEN-1];
    neg_b_in    = signed_b_in && bus.b[XLEN-1];
    mag_a_in    = neg_a_in ? -bus.a : bus.a;
    mag_b_in    = neg_b_in ? -bus.b : bus.b;
  end

  // ---------------- iteration step ----------------
  // Multiply keeps {partial_hi, multiplier_lo}: add b when the current
  // multiplier bit is set, then shift right with the carry coming in on top.
  // Divide keeps {remainder, quotient}: shift left, trial-subtract on
  // XLEN+1 bits so the shifted remainder cannot overflow.
  always_comb begin
    mul_sum  = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, mag_b} : {(XLEN+1){1'b0}});
    mul_next = {mul_sum, acc[XLEN-1:1]};
    rem_sh   = acc[2*XLEN-1:XLEN-1];
    rem_ok   = (rem_sh >= {1'b0, mag_b});
    rem_new  = rem_ok ? (rem_sh - {1'b0, mag_b}) : rem_sh;
    div_next = {rem_new[XLEN-1:0], acc[XLEN-2:0], rem_ok};
  end

  // ---------------- sign fix and result select ----------------
  always_comb begin
    prod_fix = (sign_a ^ sign_b) ? -acc : acc;
    quo_fix  = (sign_a ^ sign_b) ? -acc[XLEN-1:0] : acc[XLEN-1:0];
    rem_fix  = sign_a ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];
    fix_val  = '0;
    case (op)
      3'b000:                 fix_val = prod_fix[XLEN-1:0];
      3'b001, 3'b010, 3'b011: fix_val = prod_fix[2*XLEN-1:XLEN];
      3'b100, 3'b101: begin
        if (div0)     fix_val = '1;
        else if (ovf) fix_val = a_raw;
        else          fix_val = quo_fix;
      end
      default: begin
        if (div0)     fix_val = a_raw;
        else if (ovf) fix_val = '0;
        else          fix_val = rem_fix;
      end
    endcase
  end

  // ---------------- datapath registers ----------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt      <= '0;
      op       <= '0;
      a_raw    <= '0;
      mag_b    <= '0;
      sign_a   <= 1'b0;
      sign_b   <= 1'b0;
      div0     <= 1'b0;
      ovf      <= 1'b0;
      acc      <= '0;
      result_q <= '0;
    end else if (accept) begin
      cnt    <= '0;
      op     <= bus.funct3;
      a_raw  <= bus.a;
      mag_b  <= mag_b_in;
      sign_a <= neg_a_in;
      sign_b <= neg_b_in;
      div0   <= (bus.b == '0);
      // Only signed DIV/REM can overflow.
      ovf    <= bus.funct3[2] && !bus.funct3[0] && (bus.a == MIN_NEG) && (bus.b == '1);
      acc    <= {{XLEN{1'b0}}, mag_a_in};
    end else if (state == CALC && !bus.flush) begin
      acc <= op[2] ? div_next : mul_next;
      cnt <= cnt + 1'b1;
    end else if (state == FIX && !bus.flush) begin
      result_q <= fix_val;
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
module tb_muldiv_unit;

  logic clk = 1'b0;
  logic reset;
  int   total = 0;
  int   bad   = 0;

  muldiv_unit_if #(.XLEN(32)) bus ();
  muldiv_unit_if #(.XLEN(8))  bus8 ();

  muldiv_unit #(.XLEN(32)) dut  (.clk(clk), .reset(reset), .bus(bus));
  muldiv_unit #(.XLEN(8))  dut8 (.clk(clk), .reset(reset), .bus(bus8));

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference model: plain 64-bit arithmetic following the RV32M rules.
  function automatic logic [31:0] ref_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    longint     sa;
    longint     sb;
    logic [63:0] p;
    logic [63:0] q;
    sa = $signed(a);
    sb = $signed(b);
    case (f)
      3'd0: begin p = sa * sb; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * longint'({32'b0, b}); return p[63:32]; end
      3'd3: begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
        q = sa / sb; return q[31:0];
      end
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        q = sa % sb; return q[31:0];
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  // Issues one op from a negedge and watches 36 cycles after acceptance.
  // poke_cyc: cycle in which a second, different start is pulsed (0 = none).
  // flush_cyc: cycle in which flush is pulsed (0 = none).
  task automatic run_op(input logic [2:0] f, input logic [31:0] av, input logic [31:0] bv,
                        input int poke_cyc, input int flush_cyc,
                        output logic [31:0] res, output int done_cyc,
                        output int done_cnt, output int busy_cnt);
    @(negedge clk);
    bus.funct3 = f; bus.a = av; bus.b = bv; bus.start = 1'b1; bus.flush = 1'b0;
    res = 'x; done_cyc = -1; done_cnt = 0; busy_cnt = 0;
    for (int cyc = 1; cyc <= 36; cyc++) begin
      @(negedge clk);
      if (bus.busy) busy_cnt++;
      if (bus.done) begin done_cnt++; done_cyc = cyc; res = bus.result; end
      bus.start = (cyc == poke_cyc);
      if (cyc == poke_cyc) begin
        bus.funct3 = 3'($urandom_range(0, 7));
        bus.a = $urandom; bus.b = $urandom;
      end
      bus.flush = (cyc == flush_cyc);
    end
    bus.start = 1'b0; bus.flush = 1'b0;
  endtask

  task automatic do_op(input string tag, input logic [2:0] f, input logic [31:0] av, input logic [31:0] bv);
    logic [31:0] res;
    int dc, dn, bc;
    run_op(f, av, bv, 0, 0, res, dc, dn, bc);
    check({tag, " result"}, res, ref_op(f, av, bv));
    check({tag, " done_cycle"}, 32'(dc), 32'd34);
    check({tag, " done_count"}, 32'(dn), 32'd1);
    check({tag, " busy_cycles"}, 32'(bc), 32'd33);
  endtask

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    logic [31:0] res, prior;
    int dc, dn, bc, first_done, second_done;
    logic [2:0] f;
    logic [31:0] av, bv;

    reset = 1'b1;
    bus.start = 1'b0; bus.flush = 1'b0; bus.funct3 = '0; bus.a = '0; bus.b = '0;
    bus8.start = 1'b0; bus8.flush = 1'b0; bus8.funct3 = '0; bus8.a = '0; bus8.b = '0;
    repeat (3) @(negedge clk);
    check("reset busy", 32'(bus.busy), 32'd0);
    check("reset done", 32'(bus.done), 32'd0);
    check("reset result", bus.result, 32'd0);
    reset = 1'b0;

    do_op("mul_7_m3", 3'd0, 32'd7, 32'hFFFF_FFFD);
    check("mul_7_m3 const", ref_op(3'd0, 32'd7, 32'hFFFF_FFFD) ^ 32'hFFFF_FFEB, 32'd0);
    do_op("mulh_min", 3'd1, 32'h8000_0000, 32'h8000_0000);
    do_op("mulhu_max", 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    do_op("mulhsu", 3'd2, 32'hFFFF_FFFF, 32'd2);
    do_op("div_m7_2", 3'd4, 32'hFFFF_FFF9, 32'd2);
    do_op("rem_m7_2", 3'd6, 32'hFFFF_FFF9, 32'd2);
    do_op("divu_100_7", 3'd5, 32'd100, 32'd7);
    do_op("remu_100_7", 3'd7, 32'd100, 32'd7);
    do_op("div_by0", 3'd4, 32'd5, 32'd0);
    do_op("divu_by0", 3'd5, 32'hFFFF_FFF9, 32'd0);
    do_op("rem_by0", 3'd6, 32'hFFFF_FFF9, 32'd0);
    do_op("remu_by0", 3'd7, 32'd5, 32'd0);
    do_op("div_ovf", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF);
    do_op("rem_ovf", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF);

    // Fixed spot values written out independently of the model.
    run_op(3'd4, 32'hFFFF_FFF9, 32'd2, 0, 0, res, dc, dn, bc);
    check("div_m7_2 literal", res, 32'hFFFF_FFFD);
    run_op(3'd1, 32'h8000_0000, 32'h8000_0000, 0, 0, res, dc, dn, bc);
    check("mulh_min literal", res, 32'h4000_0000);

    // start pulsed during CALC is ignored
    run_op(3'd5, 32'd1000, 32'd9, 5, 0, res, dc, dn, bc);
    check("poke result", res, 32'd111);
    check("poke done_count", 32'(dn), 32'd1);
    check("poke done_cycle", 32'(dc), 32'd34);
    prior = res;

    // flush at k+10: no done, result kept
    run_op(3'd0, 32'd123, 32'd456, 0, 10, res, dc, dn, bc);
    check("flush done_count", 32'(dn), 32'd0);
    check("flush busy_cycles", 32'(bc), 32'd10);
    check("flush result kept", bus.result, prior);

    // start held through DONE: second op accepted at the end of IDLE cycle 35
    @(negedge clk);
    bus.funct3 = 3'd0; bus.a = 32'd3; bus.b = 32'd5; bus.start = 1'b1;
    first_done = -1; second_done = -1; dn = 0;
    for (int cyc = 1; cyc <= 72; cyc++) begin
      @(negedge clk);
      if (bus.done) begin
        dn++;
        if (first_done < 0) first_done = cyc; else second_done = cyc;
        res = bus.result;
      end
      if (cyc == 35) check("hold idle busy", 32'(bus.busy), 32'd0);
      if (cyc == 36) begin
        check("hold reaccept busy", 32'(bus.busy), 32'd1);
        bus.start = 1'b0;
      end
    end
    check("hold first_done", 32'(first_done), 32'd34);
    check("hold second_done", 32'(second_done), 32'd69);
    check("hold done_count", 32'(dn), 32'd2);
    check("hold result", res, 32'd15);

    // reset mid-CALC
    @(negedge clk);
    bus.funct3 = 3'd3; bus.a = 32'hDEAD_BEEF; bus.b = 32'h1234_5678; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (5) @(negedge clk);
    reset = 1'b1;
    #1;
    check("midreset busy", 32'(bus.busy), 32'd0);
    check("midreset done", 32'(bus.done), 32'd0);
    check("midreset result", bus.result, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    do_op("after_reset", 3'd7, 32'd100, 32'd7);

    // randomized ops against the reference model
    for (int i = 0; i < 40; i++) begin
      f  = 3'($urandom_range(0, 7));
      av = pick_operand();
      bv = pick_operand();
      do_op($sformatf("rand%0d f%0d", i, f), f, av, bv);
    end

    // XLEN=8 instance: MULHU 0xFF * 0xFF
    @(negedge clk);
    bus8.funct3 = 3'd3; bus8.a = 8'hFF; bus8.b = 8'hFF; bus8.start = 1'b1;
    dc = -1; dn = 0; res = '0;
    for (int cyc = 1; cyc <= 12; cyc++) begin
      @(negedge clk);
      bus8.start = 1'b0;
      if (bus8.done) begin dn++; dc = cyc; res = {24'b0, bus8.result}; end
    end
    check("x8 mulhu result", res, 32'h0000_00FE);
    check("x8 done_cycle", 32'(dc), 32'd10);
    check("x8 done_count", 32'(dn), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
